// File: rtl/power_charge_if.sv
// Shot-power handshake bundle between the fire button/turn logic, the power bar
// and the flight pipeline. The master side is the power_charge block itself.
interface power_charge_if;
    logic       btn;
    logic       my_turn;
    logic       fire_ack;
    logic [4:0] in_power;
    logic       fire_valid;
    logic       charging;
    logic [4:0] bar_level;

    modport master (
        input  btn, my_turn, fire_ack,
        output in_power, fire_valid, charging, bar_level
    );

    modport slave (
        output btn, my_turn, fire_ack,
        input  in_power, fire_valid, charging, bar_level
    );
endinterface

// File: rtl/power_charge.sv
// Ping-pong shot power bar: charges while the fire button is held on our turn,
// latches the bar on release and holds a valid/ack handshake toward flight logic.
module power_charge #(
    parameter int TICK_CYCLES = 3_000_000,
    parameter int MIN_POWER   = 4,
    parameter int MAX_POWER   = 31
) (
    input  logic          clk60MHz,
    input  logic          rst,
    power_charge_if.master bus
);

    typedef enum logic [1:0] {IDLE, CHARGE, FIRE, DONE} state_e;

    localparam int               CW        = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CW-1:0]    TICK_LAST = CW'(TICK_CYCLES - 1);
    localparam logic [4:0]       LVL_MIN   = 5'(MIN_POWER);
    localparam logic [4:0]       LVL_MAX   = 5'(MAX_POWER);

    state_e        state_q, state_d;
    logic [2:0]    btn_sync_q, btn_sync_d;
    logic [CW-1:0] tick_cnt_q, tick_cnt_d;
    logic [4:0]    level_q, level_d;
    logic          dir_up_q, dir_up_d;
    logic [4:0]    in_power_q, in_power_d;
    logic          fire_valid_q, fire_valid_d;
    logic          charging_q, charging_d;

    logic btn_rise;
    logic btn_fall;
    logic tick;

    // [0],[1] form the synchronizer; [2] is the previous synchronized value for edge detect.
    assign btn_rise = btn_sync_q[1] & ~btn_sync_q[2];
    assign btn_fall = ~btn_sync_q[1] & btn_sync_q[2];
    assign tick     = (tick_cnt_q == TICK_LAST);

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        btn_sync_d   = {btn_sync_q[1:0], bus.btn};
        state_d      = state_q;
        tick_cnt_d   = tick_cnt_q;
        level_d      = level_q;
        dir_up_d     = dir_up_q;
        in_power_d   = in_power_q;
        fire_valid_d = fire_valid_q;

        unique case (state_q)
            IDLE: begin
                level_d = '0;
                if (bus.my_turn && btn_rise) begin
                    state_d    = CHARGE;
                    level_d    = LVL_MIN;
                    dir_up_d   = 1'b1;
                    tick_cnt_d = '0;
                end
            end

            CHARGE: begin
                // Losing the turn beats a release; a release beats a tick (pre-tick level is latched).
                if (!bus.my_turn) begin
                    state_d = IDLE;
                    level_d = '0;
                end else if (btn_fall) begin
                    state_d      = FIRE;
                    in_power_d   = level_q;
                    fire_valid_d = 1'b1;
                end else begin
                    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
                    if (tick) begin
                        if (dir_up_q) begin
                            if (level_q == LVL_MAX) begin
                                dir_up_d = 1'b0;
                                level_d  = LVL_MAX - 5'd1;
                            end else begin
                                level_d  = level_q + 5'd1;
                            end
                        end else begin
                            if (level_q == LVL_MIN) begin
                                dir_up_d = 1'b1;
                                level_d  = LVL_MIN + 5'd1;
                            end else begin
                                level_d  = level_q - 5'd1;
                            end
                        end
                    end
                end
            end

            FIRE: begin
                // The shot is committed here: only the acknowledge moves us on.
                if (bus.fire_ack) begin
                    fire_valid_d = 1'b0;
                    state_d      = DONE;
                end
            end

            DONE: begin
                if (!bus.my_turn) begin
                    state_d = IDLE;
                    level_d = '0;
                end
            end

            default: state_d = IDLE;
        endcase

        charging_d = (state_d == CHARGE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk60MHz or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            btn_sync_q   <= '0;
            tick_cnt_q   <= '0;
            level_q      <= '0;
            dir_up_q     <= 1'b1;
            in_power_q   <= '0;
            fire_valid_q <= 1'b0;
            charging_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            btn_sync_q   <= btn_sync_d;
            tick_cnt_q   <= tick_cnt_d;
            level_q      <= level_d;
            dir_up_q     <= dir_up_d;
            in_power_q   <= in_power_d;
            fire_valid_q <= fire_valid_d;
            charging_q   <= charging_d;
        end
    end

    assign bus.in_power   = in_power_q;
    assign bus.fire_valid = fire_valid_q;
    assign bus.charging   = charging_q;
    assign bus.bar_level  = level_q;

endmodule

// File: tb/tb_power_charge.sv
// Directed bench for power_charge with TICK_CYCLES=4, MIN_POWER=4, MAX_POWER=31.
// Each task drives one scenario and compares {fire_valid, charging, in_power, bar_level}.
module tb_power_charge;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    power_charge_if pc_if ();

    power_charge #(
        .TICK_CYCLES(4),
        .MIN_POWER  (4),
        .MAX_POWER  (31)
    ) dut (
        .clk60MHz(clk),
        .rst     (rst),
        .bus     (pc_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog expired");
    end

    logic [11:0] obs;
    assign obs = {pc_if.fire_valid, pc_if.charging, pc_if.in_power, pc_if.bar_level};

    function automatic logic [11:0] pk(input logic fv, input logic ch, input int pw, input int bar);
        return {fv, ch, 5'(pw), 5'(bar)};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string name, input logic [11:0] exp);
        logic [11:0] got;
        got = obs;
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got fv=%b ch=%b pw=%0d bar=%0d, expected fv=%b ch=%b pw=%0d bar=%0d",
                     name, got[11], got[10], got[9:5], got[4:0], exp[11], exp[10], exp[9:5], exp[4:0]);
        end
    endtask

    // Press, then hold through the 3-cycle sync latency and the given number of ticks.
    task automatic press_hold(input int ticks);
        pc_if.btn = 1'b1;
        step(3 + 4 * ticks);
    endtask

    task automatic release_btn();
        pc_if.btn = 1'b0;
        step(3);
    endtask

    task automatic ack_and_end_turn();
        pc_if.fire_ack = 1'b1;
        step(1);
        pc_if.fire_ack = 1'b0;
        pc_if.my_turn  = 1'b0;
        step(1);
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        pc_if.btn      = 1'b0;
        pc_if.my_turn  = 1'b0;
        pc_if.fire_ack = 1'b0;
        step(2);
        cmp("reset_hold", pk(0, 0, 0, 0));
        rst = 1'b0;
        step(2);
        cmp("reset_release_idle", pk(0, 0, 0, 0));
    endtask

    task automatic test_ten_ticks();
        pc_if.my_turn = 1'b1;
        pc_if.btn     = 1'b1;
        step(2);
        cmp("press_latency_2", pk(0, 0, 0, 0));
        step(1);
        cmp("press_latency_3", pk(0, 1, 0, 4));
        step(40);
        cmp("ten_ticks_bar", pk(0, 1, 0, 14));
        release_btn();
        cmp("ten_ticks_fire", pk(1, 0, 14, 14));
        pc_if.fire_ack = 1'b1;
        step(1);
        pc_if.fire_ack = 1'b0;
        cmp("ack_drops_valid", pk(0, 0, 14, 14));
        pc_if.my_turn = 1'b0;
        step(1);
        cmp("done_to_idle", pk(0, 0, 14, 0));
    endtask

    task automatic test_ping_pong();
        int exp_lvl;
        bit exp_up;
        int viol;
        pc_if.my_turn = 1'b1;
        press_hold(0);
        exp_lvl = 4;
        exp_up  = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            if (exp_up) begin
                if (exp_lvl == 31) begin exp_up = 1'b0; exp_lvl = 30; end
                else exp_lvl = exp_lvl + 1;
            end else begin
                if (exp_lvl == 4) begin exp_up = 1'b1; exp_lvl = 5; end
                else exp_lvl = exp_lvl - 1;
            end
            step(4);
            cmp($sformatf("pingpong_tick%0d", k), pk(0, 1, 14, exp_lvl));
        end
        cmp("tick30_is_28", pk(0, 1, 14, 28));
        release_btn();
        cmp("pingpong_fire", pk(1, 0, 28, 28));
        ack_and_end_turn();

        // 100-tick hold: range is watched every cycle, final level is 12.
        pc_if.my_turn = 1'b1;
        press_hold(0);
        viol = 0;
        for (int c = 0; c < 400; c++) begin
            step(1);
            if (pc_if.bar_level < 5'd4 || pc_if.bar_level > 5'd31) viol++;
        end
        total++;
        if (viol != 0) begin
            bad++;
            $display("FAIL bar_range: got %0d out-of-range cycles, expected 0", viol);
        end
        cmp("hold100_bar", pk(0, 1, 28, 12));
        release_btn();
        cmp("hold100_fire", pk(1, 0, 12, 12));
        ack_and_end_turn();
    endtask

    task automatic test_handshake();
        pc_if.my_turn = 1'b1;
        press_hold(5);
        release_btn();
        cmp("hs_fire", pk(1, 0, 9, 9));
        for (int c = 1; c <= 5; c++) begin
            step(1);
            cmp($sformatf("hs_wait%0d", c), pk(1, 0, 9, 9));
        end
        pc_if.fire_ack = 1'b1;
        step(1);
        pc_if.fire_ack = 1'b0;
        cmp("hs_acked", pk(0, 0, 9, 9));
        pc_if.btn = 1'b1;
        step(6);
        cmp("hs_repress_done", pk(0, 0, 9, 9));
        pc_if.btn = 1'b0;
        step(4);
        cmp("hs_release_done", pk(0, 0, 9, 9));
        pc_if.my_turn = 1'b0;
        step(1);
        cmp("hs_turn_off", pk(0, 0, 9, 0));
        pc_if.my_turn = 1'b1;
        press_hold(0);
        cmp("hs_new_charge", pk(0, 1, 9, 4));
        release_btn();
        cmp("hs_new_fire", pk(1, 0, 4, 4));
        ack_and_end_turn();
    endtask

    task automatic test_abort();
        pc_if.my_turn = 1'b1;
        press_hold(10);
        release_btn();
        cmp("abort_setup_fire", pk(1, 0, 14, 14));
        ack_and_end_turn();

        pc_if.my_turn = 1'b1;
        press_hold(3);
        cmp("abort_mid_charge", pk(0, 1, 14, 7));
        pc_if.my_turn = 1'b0;
        step(1);
        cmp("abort_to_idle", pk(0, 0, 14, 0));
        pc_if.btn = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            step(1);
            cmp($sformatf("abort_no_fire%0d", c), pk(0, 0, 14, 0));
        end

        // Release edge and turn loss reach the FSM on the same clock.
        pc_if.my_turn = 1'b1;
        press_hold(1);
        cmp("race_charging", pk(0, 1, 14, 5));
        pc_if.btn = 1'b0;
        step(2);
        pc_if.my_turn = 1'b0;
        step(1);
        cmp("race_no_fire", pk(0, 0, 14, 0));
        step(2);
        cmp("race_still_idle", pk(0, 0, 14, 0));
    endtask

    task automatic test_timing_corners();
        pc_if.my_turn = 1'b0;
        pc_if.btn     = 1'b1;
        step(5);
        pc_if.my_turn = 1'b1;
        step(6);
        cmp("held_btn_no_charge", pk(0, 0, 14, 0));
        release_btn();
        cmp("held_btn_release", pk(0, 0, 14, 0));
        press_hold(0);
        cmp("held_btn_repress", pk(0, 1, 14, 4));

        // Release so the falling edge lands on the second tick edge.
        step(5);
        cmp("tick_coincide_pre", pk(0, 1, 14, 5));
        release_btn();
        cmp("tick_coincide_fire", pk(1, 0, 5, 5));
        ack_and_end_turn();
    endtask

    task automatic test_async_reset();
        pc_if.my_turn = 1'b1;
        press_hold(2);
        release_btn();
        cmp("rst_fire_setup", pk(1, 0, 6, 6));
        pc_if.fire_ack = 1'b1;
        pc_if.btn      = 1'b1;
        #3;
        rst = 1'b1;
        #1;
        cmp("rst_mid_fire", pk(0, 0, 0, 0));
        step(2);
        pc_if.btn      = 1'b0;
        pc_if.fire_ack = 1'b0;
        rst            = 1'b0;
        step(1);
        cmp("rst_release_idle", pk(0, 0, 0, 0));

        press_hold(1);
        cmp("rst_charge_setup", pk(0, 1, 0, 5));
        #2;
        rst = 1'b1;
        #1;
        cmp("rst_mid_charge", pk(0, 0, 0, 0));
        step(1);
        pc_if.btn = 1'b0;
        rst       = 1'b0;
        step(4);
        cmp("rst_after_charge", pk(0, 0, 0, 0));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_ten_ticks();
        test_ping_pong();
        test_handshake();
        test_abort();
        test_timing_corners();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
